// File: rtl/rpn_stack_ctrl.sv
// rpn_stack_ctrl
// Postfix (RPN) evaluation controller placed directly in front of a Stack
// block of matching DEPTH and BANDWIDTH. It consumes operand/operator
// tokens, drives the stack's push/pop/data_in, and evaluates operators
// using the words the stack presents on data_out.
//
// Ports:
//   clk           clock, rising edge
//   rstn          asynchronous reset, active-high (shared with the Stack)
//   tok_valid     token offered
//   tok_ready     token accepted on tok_valid & tok_ready (high in IDLE)
//   tok_is_op     0 = operand, 1 = operator
//   tok_data      operand value, or opcode in [1:0] (ADD/SUB/AND/OUT)
//   stk_push      to Stack.push
//   stk_pop       to Stack.pop
//   stk_data_in   to Stack.data_in
//   stk_data_out  from Stack.data_out (popped word, valid the cycle after pop)
//   stk_full      from Stack.full
//   stk_empty     from Stack.empty
//   res_valid     one-cycle pulse, result present on res_data
//   res_data      last OUT result, held until the next res_valid
//   err_ovf       sticky overflow flag (operand dropped on a full stack)
//   err_udf       sticky underflow flag (operator dropped, too few words)
//   depth         local count of stacked words
//
// state | meaning
// IDLE  | waiting for a token, tok_ready high
// PUSH  | pushing the latched operand
// POP1  | popping the top word (b, or the OUT value)
// POP2  | popping a; b visible on stk_data_out
// CALC  | a visible on stk_data_out; result registered
// PUSHR | pushing the result
// EMIT  | OUT value visible on stk_data_out; res_valid next cycle
module rpn_stack_ctrl #(
  parameter int BANDWIDTH = 4,
  parameter int DEPTH     = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         tok_valid,
  output logic                         tok_ready,
  input  logic                         tok_is_op,
  input  logic [BANDWIDTH-1:0]         tok_data,
  output logic                         stk_push,
  output logic                         stk_pop,
  output logic [BANDWIDTH-1:0]         stk_data_in,
  input  logic [BANDWIDTH-1:0]         stk_data_out,
  input  logic                         stk_full,
  input  logic                         stk_empty,
  output logic                         res_valid,
  output logic [BANDWIDTH-1:0]         res_data,
  output logic                         err_ovf,
  output logic                         err_udf,
  output logic [$clog2(DEPTH+1)-1:0]   depth
);

  localparam int DW = $clog2(DEPTH+1);
  localparam logic [DW-1:0] DEPTH_C = DW'(DEPTH);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OUT = 2'b11;

  typedef enum logic [2:0] {IDLE, PUSH, POP1, POP2, CALC, PUSHR, EMIT} state_t;

  state_t               state, state_nxt;
  logic [BANDWIDTH-1:0] opd_q;
  logic [1:0]           op_q;
  logic [BANDWIDTH-1:0] b_q;
  logic [BANDWIDTH-1:0] result_q;
  logic [BANDWIDTH-1:0] calc_val;
  logic                 ld_opd;
  logic                 ld_op;
  logic                 set_ovf;
  logic                 set_udf;

  always_comb begin
    state_nxt   = state;
    tok_ready   = 1'b0;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_data_in = '0;
    ld_opd      = 1'b0;
    ld_op       = 1'b0;
    set_ovf     = 1'b0;
    set_udf     = 1'b0;
    case (state)
      IDLE: begin
        tok_ready = 1'b1;
        if (tok_valid) begin
          if (!tok_is_op) begin
            if (depth == DEPTH_C || stk_full) begin
              set_ovf = 1'b1;
            end else begin
              ld_opd    = 1'b1;
              state_nxt = PUSH;
            end
          end else if (tok_data[1:0] == OP_OUT) begin
            if (depth == '0 || stk_empty) begin
              set_udf = 1'b1;
            end else begin
              ld_op     = 1'b1;
              state_nxt = POP1;
            end
          end else begin
            if (depth < DW'(2) || stk_empty) begin
              set_udf = 1'b1;
            end else begin
              ld_op     = 1'b1;
              state_nxt = POP1;
            end
          end
        end
      end
      PUSH: begin
        stk_push    = 1'b1;
        stk_data_in = opd_q;
        state_nxt   = IDLE;
      end
      POP1: begin
        stk_pop   = 1'b1;
        state_nxt = (op_q == OP_OUT) ? EMIT : POP2;
      end
      POP2: begin
        stk_pop   = 1'b1;
        state_nxt = CALC;
      end
      CALC: state_nxt = PUSHR;
      PUSHR: begin
        stk_push    = 1'b1;
        stk_data_in = result_q;
        state_nxt   = IDLE;
      end
      EMIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // In CALC, stk_data_out carries a (second pop); b was captured in POP2.
  always_comb begin
    calc_val = stk_data_out;
    case (op_q)
      OP_ADD: calc_val = stk_data_out + b_q;
      OP_SUB: calc_val = stk_data_out - b_q;
      OP_AND: calc_val = stk_data_out & b_q;
      default: calc_val = stk_data_out;
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state     <= IDLE;
      depth     <= '0;
      opd_q     <= '0;
      op_q      <= '0;
      b_q       <= '0;
      result_q  <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      err_ovf   <= 1'b0;
      err_udf   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ld_opd) opd_q <= tok_data;
      if (ld_op)  op_q  <= tok_data[1:0];
      if (state == POP2) b_q <= stk_data_out;
      if (state == CALC) result_q <= calc_val;
      if (stk_push)     depth <= depth + DW'(1);
      else if (stk_pop) depth <= depth - DW'(1);
      res_valid <= (state == EMIT);
      if (state == EMIT) res_data <= stk_data_out;
      if (set_ovf) err_ovf <= 1'b1;
      if (set_udf) err_udf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
module tb_rpn_stack_ctrl;

  localparam int BW = 4;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          tok_valid;
  logic          tok_ready;
  logic          tok_is_op;
  logic [BW-1:0] tok_data;
  logic          stk_push;
  logic          stk_pop;
  logic [BW-1:0] stk_data_in;
  logic [BW-1:0] stk_data_out;
  logic          stk_full;
  logic          stk_empty;
  logic          res_valid;
  logic [BW-1:0] res_data;
  logic          err_ovf;
  logic          err_udf;
  logic [3:0]    depth;

  always #5 clk = ~clk;

  rpn_stack_ctrl #(.BANDWIDTH(BW), .DEPTH(D)) dut (
    .clk(clk), .rstn(rstn),
    .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_is_op(tok_is_op), .tok_data(tok_data),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in),
    .stk_data_out(stk_data_out), .stk_full(stk_full), .stk_empty(stk_empty),
    .res_valid(res_valid), .res_data(res_data),
    .err_ovf(err_ovf), .err_udf(err_udf), .depth(depth)
  );

  // Behavioural Stack: popped word appears on data_out the cycle after pop.
  logic [BW-1:0] smem [D];
  logic [3:0]    sp;
  always @(posedge clk or posedge rstn) begin
    if (rstn) begin
      sp           <= '0;
      stk_data_out <= '0;
    end else if (stk_push && sp < 4'(D)) begin
      smem[sp[2:0]] <= stk_data_in;
      sp            <= sp + 4'd1;
    end else if (stk_pop && sp != 4'd0) begin
      stk_data_out <= smem[sp[2:0] - 3'd1];
      sp           <= sp - 4'd1;
    end
  end
  assign stk_full  = (sp == 4'(D));
  assign stk_empty = (sp == 4'd0);

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int push_cnt = 0;
  logic [BW-1:0] exp_push [$];
  logic [BW-1:0] exp_res [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard
  logic prev_rv = 1'b0;
  always @(negedge clk) begin
    if (rstn) begin
      prev_rv = 1'b0;
    end else begin
      chk("push_pop_exclusive", int'(stk_push && stk_pop), 0);
      if (stk_push) begin
        push_cnt++;
        if (exp_push.size() == 0) chk("unexpected_push", int'(stk_data_in), -1);
        else chk("push_data", int'(stk_data_in), int'(exp_push.pop_front()));
      end
      if (stk_pop) pop_cnt++;
      if (res_valid) begin
        chk("res_valid_single_cycle", int'(prev_rv), 0);
        if (exp_res.size() == 0) chk("unexpected_res", int'(res_data), -1);
        else chk("res_data", int'(res_data), int'(exp_res.pop_front()));
      end
      prev_rv = res_valid;
      chk("depth_vs_stack", int'(depth), int'(sp));
    end
  end

  int acc_cyc;

  task automatic send(input bit op, input logic [BW-1:0] d);
    int n;
    n = 0;
    tok_valid = 1'b1;
    tok_is_op = op;
    tok_data  = d;
    forever begin
      @(negedge clk);
      if (tok_ready) break;
      n++;
      if (n > 50) begin
        chk("tok_ready_timeout", 0, 1);
        break;
      end
    end
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    tok_valid = 1'b0;
  endtask

  task automatic opd(input logic [BW-1:0] v);
    send(1'b0, v);
    exp_push.push_back(v);
  endtask

  task automatic binop(input logic [1:0] op, input logic [BW-1:0] r);
    send(1'b1, {2'b00, op});
    exp_push.push_back(r);
  endtask

  task automatic out(input logic [BW-1:0] r);
    send(1'b1, 4'd3);
    exp_res.push_back(r);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int p0, q0, c0, c1, c2, c3;

  initial begin
    rstn = 1'b1; tok_valid = 1'b0; tok_is_op = 1'b0; tok_data = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("rst_tok_ready", int'(tok_ready), 1);
    chk("rst_depth", int'(depth), 0);
    chk("rst_err_ovf", int'(err_ovf), 0);
    chk("rst_err_udf", int'(err_udf), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_strobes", int'({stk_push, stk_pop}), 0);
    chk("rst_data_in", int'(stk_data_in), 0);

    // 3 + 5
    p0 = pop_cnt;
    opd(4'd3); opd(4'd5); binop(2'b00, 4'd8); out(4'd8);
    settle(6);
    chk("t1_depth", int'(depth), 0);
    chk("t1_pops", pop_cnt - p0, 3);
    chk("t1_res_hold", int'(res_data), 8);
    chk("t1_errs", int'({err_ovf, err_udf}), 0);

    // 2 - 5 wraps to 13; 6 & 3 = 2
    opd(4'd2); opd(4'd5); binop(2'b01, 4'd13); out(4'd13);
    opd(4'd6); opd(4'd3); binop(2'b10, 4'd2); out(4'd2);
    settle(6);
    chk("t2_depth", int'(depth), 0);
    chk("t2_errs", int'({err_ovf, err_udf}), 0);

    // Overflow
    for (int i = 0; i < 8; i++) opd(4'(i));
    settle(3);
    chk("t3_depth_full", int'(depth), 8);
    q0 = push_cnt;
    send(1'b0, 4'd9);
    chk("t3_err_ovf", int'(err_ovf), 1);
    settle(3);
    chk("t3_no_push", push_cnt - q0, 0);
    chk("t3_depth_held", int'(depth), 8);
    for (int i = 7; i >= 0; i--) out(4'(i));
    settle(5);
    chk("t3_depth_drained", int'(depth), 0);
    chk("t3_ovf_sticky", int'(err_ovf), 1);
    chk("t3_udf_clear", int'(err_udf), 0);

    // Underflow
    p0 = pop_cnt;
    send(1'b1, 4'd0);
    chk("t4_err_udf", int'(err_udf), 1);
    opd(4'd4);
    send(1'b1, 4'd1);
    settle(3);
    chk("t4_no_pops", pop_cnt - p0, 0);
    chk("t4_depth", int'(depth), 1);
    out(4'd4);
    settle(5);
    chk("t4_out_pops", pop_cnt - p0, 1);
    chk("t4_depth_end", int'(depth), 0);

    // Back-to-back acceptance timing
    opd(4'd1); c0 = acc_cyc;
    opd(4'd1); c1 = acc_cyc;
    binop(2'b00, 4'd2); c2 = acc_cyc;
    out(4'd2); c3 = acc_cyc;
    settle(5);
    chk("t5_acc_push2", c1 - c0, 2);
    chk("t5_acc_add", c2 - c0, 4);
    chk("t5_acc_out", c3 - c0, 9);
    chk("t5_res_hold", int'(res_data), 2);

    // Reset during POP2 of an ADD
    opd(4'd1); opd(4'd2);
    send(1'b1, 4'd0);
    @(posedge clk);
    #1;
    chk("t6_in_pop2_pop", int'(stk_pop), 1);
    chk("t6_in_pop2_ready", int'(tok_ready), 0);
    rstn = 1'b1;
    #1;
    chk("t6_ready", int'(tok_ready), 1);
    chk("t6_depth", int'(depth), 0);
    chk("t6_strobes", int'({stk_push, stk_pop}), 0);
    chk("t6_flags", int'({err_ovf, err_udf}), 0);
    chk("t6_res", int'({res_valid, res_data}), 0);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    opd(4'd7); out(4'd7);
    settle(6);
    chk("t6_depth_end", int'(depth), 0);

    chk("push_queue_drained", exp_push.size(), 0);
    chk("res_queue_drained", exp_res.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rpn_stack_ctrl.md
# rpn_stack_ctrl

Postfix (RPN) evaluation controller that sits directly in front of the `Stack` block, with the same DEPTH and BANDWIDTH. It accepts a stream of operand and operator tokens and drives the stack's push, pop and data_in ports. It reads the stack's data_out, full and empty outputs to evaluate operators and emit results. The stack and this block share clock and reset.

## Interface
Parameters:
- BANDWIDTH, 4: data and stack word width.
- DEPTH, 8: stack depth; must equal the attached `Stack` DEPTH.

Ports:
- clk  in  1: single clock; all state changes on the rising edge.
- rstn  in  1: reset, asynchronous, active-high (name kept per codebase; asserted = 1). The same net resets the attached `Stack`.
- tok_valid  in  1: token offered.
- tok_ready  out  1: token accepted on an edge where tok_valid & tok_ready.
- tok_is_op  in  1: 0 = operand, 1 = operator.
- tok_data  in  BANDWIDTH: operand value, or opcode in bits [1:0].
- stk_push  out  1: to `Stack.push`.
- stk_pop  out  1: to `Stack.pop`.
- stk_data_in  out  BANDWIDTH: to `Stack.data_in`.
- stk_data_out  in  BANDWIDTH: from `Stack.data_out`.
- stk_full  in  1: from `Stack.full`.
- stk_empty  in  1: from `Stack.empty`.
- res_valid  out  1: one-cycle pulse, result present.
- res_data  out  BANDWIDTH: result value, held until the next res_valid.
- err_ovf  out  1: sticky overflow flag.
- err_udf  out  1: sticky underflow flag.
- depth  out  $clog2(DEPTH+1): local count of stacked words.

## Operation

Opcodes (tok_data[1:0]):
- 00 ADD: pops b (top), then a; pushes (a+b) mod 2^BANDWIDTH.
- 01 SUB: pops b, then a; pushes (a−b) mod 2^BANDWIDTH (two's-complement wrap).
- 10 AND: pops b, then a; pushes a&b.
- 11 OUT: pops top into res_data; pulses res_valid.

Stack contract:
- The stack samples push/pop on the rising edge.
- A pop presents the popped word on stk_data_out from the following cycle.
- stk_push and stk_pop are never asserted in the same cycle.

FSM states: IDLE, PUSH, POP1, POP2, CALC, PUSHR, EMIT.
- IDLE: tok_ready=1, all other strobes 0. On an accepted token:
  - operand: if depth==DEPTH or stk_full, set err_ovf, drop the token, stay IDLE; else latch the operand, go PUSH.
  - binary op: if depth<2 or stk_empty, set err_udf, drop the token, stay IDLE; else go POP1.
  - OUT: if depth==0 or stk_empty, set err_udf, stay IDLE; else go POP1.
- PUSH: stk_push=1, stk_data_in = latched operand; depth+1; go IDLE.
- POP1: stk_pop=1; depth−1; binary op → POP2, OUT → EMIT.
- POP2: stk_pop=1; capture b = stk_data_out; depth−1; go CALC.
- CALC: capture a = stk_data_out; compute result into a register; go PUSHR.
- PUSHR: stk_push=1, stk_data_in = result; depth+1; go IDLE.
- EMIT: res_data <= stk_data_out, with res_valid=1 on the cycle after EMIT; go IDLE.

Error flags:
- Sticky until reset.
- An error never causes any stk_push or stk_pop.

Reset (rstn=1, asynchronous):
- state IDLE, depth 0, err_ovf/err_udf 0, res_valid 0, res_data 0, stk_push/stk_pop 0, stk_data_in 0.
- tok_ready reads 1 once rstn deasserts.
- Reset mid-operation abandons the operation; the stack is cleared by the same reset.

## Timing
- tok_ready = (state==IDLE); it is low in every other state, so tokens stall under backpressure.
- Operand: accept edge, then 1 PUSH cycle; next token accepted 2 cycles after the previous one.
- Binary op: accept, POP1, POP2, CALC, PUSHR; next token accepted 5 cycles later. The result is on the stack after the PUSHR edge.
- OUT: accept, POP1, EMIT; res_valid high the cycle after EMIT, concurrent with IDLE; next token accepted 3 cycles later.
- A dropped (error) token costs 1 cycle; the flag is visible the cycle after the accept edge.
- depth always equals the attached stack's occupancy after each edge.

## Test plan
- Reset, then push 3, push 5, ADD, OUT → stk_push with 3, 5, then 8; res_valid one cycle with res_data=8; depth 0; no errors.
- Push 2, push 5, SUB, OUT → res_data=13 (4-bit wrap); push 6, push 3, AND, OUT → res_data=2.
- Push 0..7 (depth 8, stk_full=1), then push 9 → err_ovf=1, no stk_push, depth stays 8; OUT → res_data=7.
- From empty, ADD → err_udf=1, no stk_pop; push 4, SUB → no pops, depth 1; OUT → res_data=4.
- tok_valid held high for push 1, push 1, ADD, OUT back-to-back → accepts exactly at cycles 0, 2, 4, 9; stk_push and stk_pop never both high; res_data=2.
- Assert rstn during POP2 of an ADD → immediately state IDLE, depth 0, all strobes and flags 0; next push 7, OUT → res_data=7.
